// File: rtl/obstacle_spawner_pkg.sv
// Shared game definitions for the obstacle track: lane geometry, row packing and
// the spawner state encoding used by the renderer and collision logic alike.
package obstacle_spawner_pkg;

   localparam int NUM_LANES  = 3;
   localparam int LANE_W     = NUM_LANES;
   localparam int ROW_STRIDE = NUM_LANES;   // track row r lives at [ROW_STRIDE*r +: LANE_W]
   localparam int RND_W      = 20;
   localparam int CNT_W      = 16;

   typedef logic [LANE_W-1:0] lane_mask_t;

   localparam lane_mask_t LANE_NONE = 3'b000;
   localparam lane_mask_t LANE_ALL  = 3'b111;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WARMUP = 2'd1,
      RUN    = 2'd2
   } state_t;

endpackage

// File: rtl/obstacle_row_gen.sv
// Maps the effective random word to a passable, non-empty obstacle row and the
// number of empty rows that must follow it.
module obstacle_row_gen
   import obstacle_spawner_pkg::*;
#(
   parameter int MIN_GAP = 2,
   parameter int MAX_GAP = 5,
   parameter int GAP_W   = 3
) (
   input  logic [7:0]       e_low,
   output lane_mask_t       pattern,
   output logic [GAP_W-1:0] gap
);

   localparam int GAP_SPAN = MAX_GAP - MIN_GAP + 1;

   logic [1:0] lane_sel_s;
   lane_mask_t raw_s;
   lane_mask_t one_hot_s;

   // Lane fixups for full/empty patterns and the bounded gap length.
   always_comb begin
      raw_s      = e_low[2:0];
      lane_sel_s = (e_low[4:3] == 2'd3) ? 2'd0 : e_low[4:3];
      one_hot_s  = lane_mask_t'(3'b001 << lane_sel_s);
      case (raw_s)
         LANE_ALL:  pattern = LANE_ALL ^ one_hot_s;
         LANE_NONE: pattern = one_hot_s;
         default:   pattern = raw_s;
      endcase
      gap = GAP_W'(MIN_GAP + (int'(e_low[7:5]) % GAP_SPAN));
   end

endmodule

// File: rtl/obstacle_spawner.sv
// Scrolling obstacle track for the 3-lane runner: shifts one row per game step
// and inserts either an enforced gap row or a random passable obstacle row.
module obstacle_spawner
   import obstacle_spawner_pkg::*;
#(
   parameter int DEPTH       = 8,
   parameter int WARMUP_ROWS = 4,
   parameter int MIN_GAP     = 2,
   parameter int MAX_GAP     = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      game_active,
   input  logic                      step,
   input  logic [RND_W-1:0]          random_number,
   output logic [ROW_STRIDE*DEPTH-1:0] track,
   output logic [LANE_W-1:0]         near_row,
   output logic                      spawn_pulse,
   output logic                      row_passed,
   output logic [CNT_W-1:0]          rows_spawned
);

   localparam int TRACK_W = ROW_STRIDE * DEPTH;
   localparam int GAP_W   = $clog2(MAX_GAP + 2);
   localparam int WARM_W  = $clog2(WARMUP_ROWS + 2);

   state_t               state_r, state_s;
   logic [TRACK_W-1:0]   track_r, track_s;
   logic                 spawn_r, spawn_s;
   logic                 passed_r, passed_s;
   logic [CNT_W-1:0]     cnt_r, cnt_s;
   logic [GAP_W-1:0]     gap_cnt_r, gap_cnt_s;
   logic [WARM_W-1:0]    warm_cnt_r, warm_cnt_s;
   logic [RND_W-1:0]     rnd_used_r, rnd_used_s;
   logic [RND_W-1:0]     e_s;
   lane_mask_t           gen_pattern_s;
   logic [GAP_W-1:0]     gen_gap_s;

   // A repeated LFSR word is perturbed by the spawn count so stalls still vary the track.
   assign e_s = (random_number != rnd_used_r) ? random_number
                                              : (random_number ^ {4'b0000, cnt_r});

   obstacle_row_gen #(
      .MIN_GAP (MIN_GAP),
      .MAX_GAP (MAX_GAP),
      .GAP_W   (GAP_W)
   ) u_row_gen (
      .e_low   (e_s[7:0]),
      .pattern (gen_pattern_s),
      .gap     (gen_gap_s)
   );

   // Next-state, track shift and counter update logic.
   always_comb begin
      state_s    = state_r;
      track_s    = track_r;
      spawn_s    = 1'b0;
      passed_s   = 1'b0;
      cnt_s      = cnt_r;
      gap_cnt_s  = gap_cnt_r;
      warm_cnt_s = warm_cnt_r;
      rnd_used_s = rnd_used_r;
      case (state_r)
         IDLE: begin
            track_s = {TRACK_W{1'b0}};
            cnt_s   = {CNT_W{1'b0}};
            if (game_active) begin
               state_s    = WARMUP;
               warm_cnt_s = WARM_W'(WARMUP_ROWS);
            end else begin
               state_s = IDLE;
            end
         end
         WARMUP: begin
            if (!game_active) begin
               state_s = IDLE;
               track_s = {TRACK_W{1'b0}};
               cnt_s   = {CNT_W{1'b0}};
            end else if (step) begin
               track_s    = {LANE_NONE, track_r[TRACK_W-1:ROW_STRIDE]};
               passed_s   = (track_r[LANE_W-1:0] != LANE_NONE);
               warm_cnt_s = warm_cnt_r - WARM_W'(1);
               if (warm_cnt_r == WARM_W'(1)) begin
                  state_s   = RUN;
                  gap_cnt_s = {GAP_W{1'b0}};
               end else begin
                  state_s = WARMUP;
               end
            end else begin
               state_s = WARMUP;
            end
         end
         RUN: begin
            if (!game_active) begin
               state_s = IDLE;
               track_s = {TRACK_W{1'b0}};
               cnt_s   = {CNT_W{1'b0}};
            end else if (step) begin
               passed_s = (track_r[LANE_W-1:0] != LANE_NONE);
               if (gap_cnt_r != {GAP_W{1'b0}}) begin
                  track_s   = {LANE_NONE, track_r[TRACK_W-1:ROW_STRIDE]};
                  gap_cnt_s = gap_cnt_r - GAP_W'(1);
               end else begin
                  track_s    = {gen_pattern_s, track_r[TRACK_W-1:ROW_STRIDE]};
                  spawn_s    = 1'b1;
                  cnt_s      = cnt_r + 16'd1;
                  gap_cnt_s  = gen_gap_s;
                  rnd_used_s = random_number;
               end
            end else begin
               state_s = RUN;
            end
         end
         default: begin
            state_s = IDLE;
            track_s = {TRACK_W{1'b0}};
            cnt_s   = {CNT_W{1'b0}};
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         track_r    <= {TRACK_W{1'b0}};
         spawn_r    <= 1'b0;
         passed_r   <= 1'b0;
         cnt_r      <= {CNT_W{1'b0}};
         gap_cnt_r  <= {GAP_W{1'b0}};
         warm_cnt_r <= {WARM_W{1'b0}};
         rnd_used_r <= {RND_W{1'b0}};
      end else begin
         state_r    <= state_s;
         track_r    <= track_s;
         spawn_r    <= spawn_s;
         passed_r   <= passed_s;
         cnt_r      <= cnt_s;
         gap_cnt_r  <= gap_cnt_s;
         warm_cnt_r <= warm_cnt_s;
         rnd_used_r <= rnd_used_s;
      end
   end

   assign track        = track_r;
   assign near_row     = track_r[LANE_W-1:0];
   assign spawn_pulse  = spawn_r;
   assign row_passed   = passed_r;
   assign rows_spawned = cnt_r;

endmodule

// File: tb/tb_obstacle_spawner.sv
// Self-checking bench for obstacle_spawner: directed scenarios plus randomized
// play compared every cycle against a row-list model of the track.
module tb_obstacle_spawner;

   localparam int DEPTH       = 8;
   localparam int WARMUP_ROWS = 4;
   localparam int MIN_GAP     = 2;
   localparam int MAX_GAP     = 5;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 game_active;
   logic                 step;
   logic [19:0]          random_number;
   logic [3*DEPTH-1:0]   track;
   logic [2:0]           near_row;
   logic                 spawn_pulse;
   logic                 row_passed;
   logic [15:0]          rows_spawned;

   obstacle_spawner #(
      .DEPTH       (DEPTH),
      .WARMUP_ROWS (WARMUP_ROWS),
      .MIN_GAP     (MIN_GAP),
      .MAX_GAP     (MAX_GAP)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .game_active   (game_active),
      .step          (step),
      .random_number (random_number),
      .track         (track),
      .near_row      (near_row),
      .spawn_pulse   (spawn_pulse),
      .row_passed    (row_passed),
      .rows_spawned  (rows_spawned)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   bit check_en = 1'b0;

   // Inputs as seen by the DUT at the last rising edge.
   logic        s_rst, s_ga, s_step;
   logic [19:0] s_rn;

   // Reference model: mode 0=idle, 1=warming up, 2=running.
   int          m_mode = 0;
   int          m_rows[DEPTH];
   int          m_gap = 0, m_warm = 0, m_cnt = 0;
   int          m_used = 0;
   bit          m_spawn = 1'b0, m_pass = 1'b0;
   bit          run_step = 1'b0;
   bit          have_prev = 1'b0;
   int          gap_seen = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_rows();
      for (int r = 0; r < DEPTH; r++) m_rows[r] = 0;
   endtask

   task automatic model_step();
      int e, pat, ls, newrow;
      m_spawn  = 1'b0;
      m_pass   = 1'b0;
      run_step = 1'b0;
      if (s_rst) begin
         m_mode = 0; clear_rows(); m_cnt = 0; m_gap = 0; m_warm = 0; m_used = 0;
         have_prev = 1'b0;
      end else if (m_mode == 0) begin
         clear_rows();
         m_cnt = 0;
         if (s_ga) begin
            m_mode = 1;
            m_warm = WARMUP_ROWS;
         end
      end else if (!s_ga) begin
         m_mode = 0; clear_rows(); m_cnt = 0;
         have_prev = 1'b0;
      end else if (s_step) begin
         newrow = 0;
         if (m_mode == 1) begin
            m_warm = m_warm - 1;
            if (m_warm == 0) begin
               m_mode = 2;
               m_gap  = 0;
            end
         end else begin
            run_step = 1'b1;
            if (m_gap > 0) begin
               m_gap = m_gap - 1;
            end else begin
               e   = (int'(s_rn) != m_used) ? int'(s_rn) : (int'(s_rn) ^ m_cnt);
               pat = e % 8;
               ls  = ((e / 8) % 4) % 3;
               if (pat == 7) pat = 7 - (1 << ls);
               else if (pat == 0) pat = 1 << ls;
               newrow  = pat;
               m_gap   = MIN_GAP + ((e / 32) % 8) % (MAX_GAP - MIN_GAP + 1);
               m_used  = int'(s_rn);
               m_cnt   = (m_cnt + 1) % 65536;
               m_spawn = 1'b1;
            end
         end
         m_pass = (m_rows[0] != 0);
         for (int r = 0; r < DEPTH - 1; r++) m_rows[r] = m_rows[r + 1];
         m_rows[DEPTH - 1] = newrow;
      end
   endtask

   always @(posedge clk) begin
      s_rst  <= rst;
      s_ga   <= game_active;
      s_step <= step;
      s_rn   <= random_number;
   end

   // Advance the model on the falling edge, then compare every output.
   always @(negedge clk) begin
      logic [3*DEPTH-1:0] exp_track;
      bit                 any_full;
      if (check_en) begin
         model_step();
         for (int r = 0; r < DEPTH; r++) exp_track[3*r +: 3] = 3'(m_rows[r]);
         chk("track", 64'(track), 64'(exp_track));
         chk("near_row", 64'(near_row), 64'(exp_track[2:0]));
         chk("spawn_pulse", 64'(spawn_pulse), 64'(m_spawn));
         chk("row_passed", 64'(row_passed), 64'(m_pass));
         chk("rows_spawned", 64'(rows_spawned), 64'(m_cnt));
         any_full = 1'b0;
         for (int r = 0; r < DEPTH; r++) if (track[3*r +: 3] == 3'b111) any_full = 1'b1;
         chk("no_full_row", 64'(any_full), 64'd0);
         if (run_step) begin
            if (spawn_pulse) begin
               if (have_prev) begin
                  chk("gap_min", 64'(gap_seen >= MIN_GAP), 64'd1);
                  chk("gap_max", 64'(gap_seen <= MAX_GAP), 64'd1);
               end
               have_prev = 1'b1;
               gap_seen  = 0;
            end else begin
               gap_seen++;
            end
         end
      end
   end

   task automatic do_step();
      @(negedge clk);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
   endtask

   initial begin
      rst = 1'b1; game_active = 1'b0; step = 1'b0; random_number = 20'h00000;
      @(negedge clk);
      @(negedge clk);
      check_en = 1'b1;
      @(negedge clk);
      chk("reset_track", 64'(track), 64'd0);
      chk("reset_count", 64'(rows_spawned), 64'd0);
      rst = 1'b0;

      // Warm-up then stale-zero spawns.
      game_active = 1'b1;
      @(negedge clk);
      for (int i = 0; i < WARMUP_ROWS; i++) begin
         do_step();
         chk("warm_no_spawn", 64'(spawn_pulse), 64'd0);
         chk("warm_track", 64'(track), 64'd0);
      end
      do_step();
      chk("first_row", 64'(track[23:21]), 64'h1);
      chk("first_spawn", 64'(spawn_pulse), 64'd1);
      chk("first_count", 64'(rows_spawned), 64'd1);
      for (int i = 0; i < 2; i++) begin
         do_step();
         chk("gap_row", 64'(track[23:21]), 64'h0);
      end
      do_step();
      chk("stale_row", 64'(track[23:21]), 64'h1);
      chk("stale_count", 64'(rows_spawned), 64'd2);

      // Full pattern gets one lane opened.
      repeat (2) do_step();
      random_number = 20'h0001F;
      do_step();
      chk("full_fix_row", 64'(track[23:21]), 64'h6);

      // Longest gap, then follow that row down to the player.
      repeat (2) do_step();
      random_number = 20'h000E0;
      do_step();
      chk("e0_row", 64'(track[23:21]), 64'h1);
      for (int i = 0; i < 5; i++) begin
         do_step();
         chk("long_gap_row", 64'(track[23:21]), 64'h0);
         chk("long_gap_spawn", 64'(spawn_pulse), 64'd0);
      end
      do_step();
      chk("after_gap_spawn", 64'(spawn_pulse), 64'd1);
      do_step();
      chk("e0_at_near", 64'(near_row), 64'h1);
      chk("e0_not_passed", 64'(row_passed), 64'd0);
      do_step();
      chk("e0_passed", 64'(row_passed), 64'd1);

      // Deactivation in the same cycle as a step.
      @(negedge clk);
      game_active = 1'b0;
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      chk("drop_track", 64'(track), 64'd0);
      chk("drop_spawn", 64'(spawn_pulse), 64'd0);
      chk("drop_passed", 64'(row_passed), 64'd0);
      chk("drop_count", 64'(rows_spawned), 64'd0);

      // Reset in the middle of a run.
      game_active = 1'b1;
      random_number = 20'h0001F;
      @(negedge clk);
      repeat (10) do_step();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      game_active = 1'b0;
      chk("midrst_track", 64'(track), 64'd0);
      chk("midrst_count", 64'(rows_spawned), 64'd0);
      do_step();
      chk("idle_step_track", 64'(track), 64'd0);

      // Randomized play against the model.
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 599) == 0);
         if (game_active) game_active = ($urandom_range(0, 249) != 0);
         else game_active = ($urandom_range(0, 3) == 0);
         step = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 1) == 0) random_number = 20'($urandom);
      end
      @(negedge clk);
      rst = 1'b0; step = 1'b0; game_active = 1'b0;
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
